// File: rtl/fa4_share_ctrl.sv
// Round-robin front end for one shared 4-bit adder slice: accepts W-bit adds from two
// requesters and walks them through the slice LSB nibble first with a registered carry.
module fa4_share_ctrl #(
    parameter int NIBBLES = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 r0_valid_i,
    output logic                 r0_ready_o,
    input  logic [4*NIBBLES-1:0] r0_a_i,
    input  logic [4*NIBBLES-1:0] r0_b_i,
    input  logic                 r0_cin_i,
    input  logic                 r1_valid_i,
    output logic                 r1_ready_o,
    input  logic [4*NIBBLES-1:0] r1_a_i,
    input  logic [4*NIBBLES-1:0] r1_b_i,
    input  logic                 r1_cin_i,
    output logic                 rsp_valid_o,
    input  logic                 rsp_ready_i,
    output logic                 rsp_id_o,
    output logic [4*NIBBLES-1:0] rsp_sum_o,
    output logic                 rsp_cout_o,
    output logic [3:0]           add_a_o,
    output logic [3:0]           add_b_o,
    output logic                 add_cin_o,
    input  logic [3:0]           add_sum_i,
    input  logic                 add_cout_i
);
    localparam int W  = 4 * NIBBLES;
    localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

    typedef enum logic [1:0] {IDLE, ADD, RESP} state_t;
    typedef struct packed {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
    } req_t;

    state_t        state_q, state_d;
    logic [W-1:0]  a_q, a_d, b_q, b_d, sum_q, sum_d;
    logic          carry_q, carry_d, id_q, id_d, ptr_q, ptr_d;
    logic [IW-1:0] idx_q, idx_d;
    logic          gnt0, gnt1;
    req_t          req0, req1, req_sel;

    assign req0    = {r0_a_i, r0_b_i, r0_cin_i};
    assign req1    = {r1_a_i, r1_b_i, r1_cin_i};
    // ptr_q high means r1 wins a tie
    assign gnt0    = r0_valid_i & (~r1_valid_i | ~ptr_q);
    assign gnt1    = r1_valid_i & (~r0_valid_i |  ptr_q);
    assign req_sel = gnt1 ? req1 : req0;

    assign rsp_valid_o = (state_q == RESP);
    assign rsp_id_o    = id_q;
    assign rsp_sum_o   = sum_q;
    assign rsp_cout_o  = carry_q;

    always_comb begin
        state_d    = state_q;
        a_d        = a_q;
        b_d        = b_q;
        sum_d      = sum_q;
        carry_d    = carry_q;
        idx_d      = idx_q;
        id_d       = id_q;
        ptr_d      = ptr_q;
        r0_ready_o = 1'b0;
        r1_ready_o = 1'b0;
        add_a_o    = 4'h0;
        add_b_o    = 4'h0;
        add_cin_o  = 1'b0;
        unique case (state_q)
            IDLE: begin
                r0_ready_o = gnt0;
                r1_ready_o = gnt1;
                if (gnt0 || gnt1) begin
                    a_d     = req_sel.a;
                    b_d     = req_sel.b;
                    carry_d = req_sel.cin;
                    id_d    = gnt1;
                    idx_d   = '0;
                    state_d = ADD;
                end
            end
            ADD: begin
                // add_* depend only on registers, never on valid/ready inputs
                add_a_o   = a_q[4*int'(idx_q) +: 4];
                add_b_o   = b_q[4*int'(idx_q) +: 4];
                add_cin_o = carry_q;
                sum_d[4*int'(idx_q) +: 4] = add_sum_i;
                carry_d   = add_cout_i;
                idx_d     = idx_q + 1'b1;
                if (idx_q == IW'(NIBBLES - 1)) state_d = RESP;
            end
            RESP: begin
                if (rsp_ready_i) begin
                    state_d = IDLE;
                    ptr_d   = ~id_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            idx_q   <= '0;
            id_q    <= 1'b0;
            ptr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            idx_q   <= idx_d;
            id_q    <= id_d;
            ptr_q   <= ptr_d;
        end
    end
endmodule

// File: tb/tb_fa4_share_ctrl.sv
// Bench for fa4_share_ctrl (NIBBLES=4): directed table, contention, backpressure,
// reset-in-flight, nibble sweep and random ops against an arithmetic reference.
module tb_fa4_share_ctrl;
    localparam int N = 4;
    localparam int W = 4 * N;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         r0_valid = 1'b0, r0_ready, r0_cin = 1'b0;
    logic [W-1:0] r0_a = '0, r0_b = '0;
    logic         r1_valid = 1'b0, r1_ready, r1_cin = 1'b0;
    logic [W-1:0] r1_a = '0, r1_b = '0;
    logic         rsp_valid, rsp_ready = 1'b1, rsp_id, rsp_cout;
    logic [W-1:0] rsp_sum;
    logic [3:0]   add_a, add_b, add_sum;
    logic         add_cin, add_cout;

    int total = 0;
    int bad = 0;
    logic [W-1:0] g_s;
    logic         g_co, g_id;

    always #5 clk = ~clk;

    // the external slice the block drives
    assign {add_cout, add_sum} = 5'(add_a) + 5'(add_b) + 5'(add_cin);

    fa4_share_ctrl #(.NIBBLES(N)) dut (
        .clk(clk), .rst_n(rst_n),
        .r0_valid_i(r0_valid), .r0_ready_o(r0_ready), .r0_a_i(r0_a), .r0_b_i(r0_b), .r0_cin_i(r0_cin),
        .r1_valid_i(r1_valid), .r1_ready_o(r1_ready), .r1_a_i(r1_a), .r1_b_i(r1_b), .r1_cin_i(r1_cin),
        .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_id_o(rsp_id),
        .rsp_sum_o(rsp_sum), .rsp_cout_o(rsp_cout),
        .add_a_o(add_a), .add_b_o(add_b), .add_cin_o(add_cin),
        .add_sum_i(add_sum), .add_cout_i(add_cout)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    function automatic logic [W:0] ref_add(input logic [W-1:0] a, b, input logic cin);
        return (W+1)'(a) + (W+1)'(b) + (W+1)'(cin);
    endfunction

    // carry entering nibble k = overflow of the low 4k bits of a+b+cin
    function automatic logic carry_in(input logic [W-1:0] a, b, input logic cin, input int k);
        longint unsigned m, t;
        m = (64'd1 << (4*k)) - 64'd1;
        t = (64'(a) & m) + (64'(b) & m) + 64'(cin);
        return 1'((t >> (4*k)) & 64'd1);
    endfunction

    task automatic run_op(input logic id, input logic [W-1:0] a, b, input logic cin,
                          input int hold, input bit pend);
        logic [W-1:0] aseq, bseq, s0;
        logic [N-1:0] cseq, ecseq;
        logic         co0, id0;
        logic [W:0]   r;
        int           wn, lat;
        bit           busy_rdy, unstable;
        aseq = '0; bseq = '0; cseq = '0; wn = 0; lat = 0; busy_rdy = 0; unstable = 0;
        @(negedge clk);
        if (id) begin r1_valid = 1'b1; r1_a = a; r1_b = b; r1_cin = cin; end
        else    begin r0_valid = 1'b1; r0_a = a; r0_b = b; r0_cin = cin; end
        rsp_ready = (hold == 0);
        #1;
        while (!(id ? r1_ready : r0_ready) && wn < 20) begin
            @(negedge clk); #1; wn++;
        end
        chk("accept_wait", 32'(wn), 32'd0);
        if (wn >= 20) begin
            r0_valid = 1'b0; r1_valid = 1'b0; rsp_ready = 1'b1;
            return;
        end
        @(posedge clk); #1;
        r0_valid = pend; r1_valid = pend;
        forever begin
            @(negedge clk);
            if (rsp_valid || lat >= 20) break;
            if (lat < N) begin
                aseq[4*lat +: 4] = add_a;
                bseq[4*lat +: 4] = add_b;
                cseq[lat]        = add_cin;
            end
            if (r0_ready || r1_ready) busy_rdy = 1;
            lat++;
        end
        chk("rsp_latency", 32'(lat), 32'(N));
        s0 = rsp_sum; co0 = rsp_cout; id0 = rsp_id;
        if (r0_ready || r1_ready) busy_rdy = 1;
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            if (!rsp_valid || rsp_sum !== s0 || rsp_cout !== co0 || rsp_id !== id0) unstable = 1;
            if (r0_ready || r1_ready) busy_rdy = 1;
        end
        r0_valid = 1'b0; r1_valid = 1'b0; rsp_ready = 1'b1;
        @(posedge clk); #1;
        chk("rsp_done", 32'(rsp_valid), 32'd0);
        r = ref_add(a, b, cin);
        for (int k = 0; k < N; k++) ecseq[k] = carry_in(a, b, cin, k);
        chk("sum", 32'(s0), 32'(r[W-1:0]));
        chk("cout", 32'(co0), 32'(r[W]));
        chk("id", 32'(id0), 32'(id));
        chk("add_a_seq", 32'(aseq), 32'(a));
        chk("add_b_seq", 32'(bseq), 32'(b));
        chk("add_cin_seq", 32'(cseq), 32'(ecseq));
        chk("ready_while_busy", 32'(busy_rdy), 32'd0);
        chk("rsp_stable", 32'(unstable), 32'd0);
        g_s = s0; g_co = co0; g_id = id0;
    endtask

    typedef struct {
        logic         id;
        logic [W-1:0] a, b;
        logic         cin;
        logic [W-1:0] s;
        logic         co;
    } vec_t;

    initial begin
        vec_t tbl [6];
        logic [W-1:0] c_a [4], c_b [4];
        logic         c_cin [4];
        logic [W:0]   expq [$];
        logic         expid [$], gq [$];
        logic         g0, g1, rv, rid;
        logic [W-1:0] rs;
        logic         rco;
        int           p0, p1, nresp, cyc;
        bit           overlap, quiet;
        logic [3:0]   gord;

        tbl[0] = '{1'b0, 16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0};
        tbl[1] = '{1'b1, 16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1};
        tbl[2] = '{1'b0, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1};
        tbl[3] = '{1'b1, 16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0};
        tbl[4] = '{1'b0, 16'h8000, 16'h8000, 1'b1, 16'h0001, 1'b1};
        tbl[5] = '{1'b1, 16'h0F0F, 16'h00F1, 1'b0, 16'h1000, 1'b0};

        #2 rst_n = 1'b0;
        #1;
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_add", 32'({add_a, add_b, add_cin}), 32'd0);
        chk("rst_rsp_sum", 32'({rsp_sum, rsp_cout, rsp_id}), 32'd0);
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 6; i++) begin
            run_op(tbl[i].id, tbl[i].a, tbl[i].b, tbl[i].cin, 0, 0);
            chk("tbl_sum", 32'(g_s), 32'(tbl[i].s));
            chk("tbl_cout", 32'(g_co), 32'(tbl[i].co));
            chk("tbl_id", 32'(g_id), 32'(tbl[i].id));
        end

        // backpressure with both requesters waiting
        run_op(1'b0, 16'hA5A5, 16'h1111, 1'b1, 5, 1);

        // reset while nibble 2 is pending; tie must then go to r0
        run_op(1'b0, 16'h0101, 16'h0202, 1'b0, 0, 0);
        @(negedge clk);
        r0_valid = 1'b1; r0_a = 16'h7777; r0_b = 16'h1111; r0_cin = 1'b0;
        #1 chk("rst_test_accept", 32'(r0_ready), 32'd1);
        @(posedge clk); #1 r0_valid = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("midadd_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("midadd_add", 32'({add_a, add_b, add_cin}), 32'd0);
        chk("midadd_sum", 32'({rsp_sum, rsp_cout}), 32'd0);
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        quiet = 1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (rsp_valid || add_a != 4'h0 || add_cin) quiet = 0;
        end
        chk("midadd_discarded", 32'(quiet), 32'd1);
        r0_valid = 1'b1; r1_valid = 1'b1;
        #1 chk("post_rst_grant", 32'({r1_ready, r0_ready}), 32'b01);
        r0_valid = 1'b0; r1_valid = 1'b0;

        // contention: r0 owns ops 0,2 and r1 owns ops 1,3
        for (int i = 0; i < 4; i++) begin
            c_a[i] = 16'($urandom); c_b[i] = 16'($urandom); c_cin[i] = 1'($urandom);
        end
        @(posedge clk); #1;
        r0_a = c_a[0]; r0_b = c_b[0]; r0_cin = c_cin[0]; r0_valid = 1'b1;
        r1_a = c_a[1]; r1_b = c_b[1]; r1_cin = c_cin[1]; r1_valid = 1'b1;
        p0 = 0; p1 = 1; nresp = 0; cyc = 0; overlap = 0;
        while (nresp < 4 && cyc < 200) begin
            @(negedge clk);
            g0 = r0_ready; g1 = r1_ready; rv = rsp_valid;
            rs = rsp_sum; rco = rsp_cout; rid = rsp_id;
            if ((g0 && g1) || ((g0 || g1) && rv)) overlap = 1;
            @(posedge clk); #1;
            cyc++;
            if (rv) begin
                nresp++;
                if (expq.size() == 0) chk("cont_spurious_rsp", 32'd1, 32'd0);
                else begin
                    chk("cont_sum", 32'(rs), 32'(expq[0][W-1:0]));
                    chk("cont_cout", 32'(rco), 32'(expq[0][W]));
                    chk("cont_id", 32'(rid), 32'(expid[0]));
                    void'(expq.pop_front()); void'(expid.pop_front());
                end
            end
            if (g0) begin
                gq.push_back(1'b0); expid.push_back(1'b0);
                expq.push_back(ref_add(c_a[p0], c_b[p0], c_cin[p0]));
                p0 += 2;
                if (p0 < 4) begin r0_a = c_a[p0]; r0_b = c_b[p0]; r0_cin = c_cin[p0]; end
                else r0_valid = 1'b0;
            end
            if (g1) begin
                gq.push_back(1'b1); expid.push_back(1'b1);
                expq.push_back(ref_add(c_a[p1], c_b[p1], c_cin[p1]));
                p1 += 2;
                if (p1 < 4) begin r1_a = c_a[p1]; r1_b = c_b[p1]; r1_cin = c_cin[p1]; end
                else r1_valid = 1'b0;
            end
        end
        r0_valid = 1'b0; r1_valid = 1'b0;
        chk("cont_responses", 32'(nresp), 32'd4);
        chk("cont_grants", 32'(gq.size()), 32'd4);
        gord = '1;
        if (gq.size() == 4) gord = {gq[0], gq[1], gq[2], gq[3]};
        chk("cont_order", 32'(gord), 32'b0101);
        chk("cont_overlap", 32'(overlap), 32'd0);

        // nibble-0 sweep against b=5 in every nibble
        for (int k = 0; k < 16; k++)
            for (int c = 0; c < 2; c++)
                run_op(1'(k), 16'(k), 16'h5555, 1'(c), 0, 0);

        for (int i = 0; i < 40; i++)
            run_op(1'($urandom), 16'($urandom), 16'($urandom), 1'($urandom),
                   int'($urandom_range(0, 2)), 1'($urandom));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end
endmodule
